// File: rtl/reg_bus_initiator.sv
// REG_BUS initiator: queued write/read/poll commands become REG_BUS
// transactions, with exactly one response returned per command.
module reg_bus_initiator #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POLL_MAX   = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // command side
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH-1:0]   cmd_mask_i,
    // response side
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic                    rsp_timeout_o,
    output logic                    busy_o,
    // REG_BUS initiator port
    output logic [ADDR_WIDTH-1:0]   reg_bus_addr_o,
    output logic                    reg_bus_write_o,
    output logic [DATA_WIDTH-1:0]   reg_bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_bus_wstrb_o,
    output logic                    reg_bus_valid_o,
    input  logic                    reg_bus_ready_i,
    input  logic [DATA_WIDTH-1:0]   reg_bus_rdata_i,
    input  logic                    reg_bus_error_i
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]            op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] mask;
    } cmd_t;

    // ---------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------
    cmd_t             mem [FIFO_DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;
    logic             push, pop;

    state_e           state_q, state_d;

    assign push = cmd_valid_i && ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign head = mem[rd_ptr_q];

    // Pack the incoming command fields into one FIFO entry.
    always_comb begin
        cmd_in       = '0;
        cmd_in.op    = cmd_op_i;
        cmd_in.addr  = cmd_addr_i;
        cmd_in.wdata = cmd_wdata_i;
        cmd_in.mask  = cmd_mask_i;
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= cmd_in;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    // ---------------------------------------------------------------
    // Transaction FSM
    // ---------------------------------------------------------------
    op_e                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [POLL_W-1:0]     poll_cnt_q, poll_cnt_d;

    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_write_q, bus_write_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]     bus_wstrb_q, bus_wstrb_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  busy_q, busy_d;

    logic                  poll_match;
    logic                  poll_last;
    logic                  head_is_write;

    assign poll_match    = (reg_bus_rdata_i & mask_q) == (wdata_q & mask_q);
    assign poll_last     = (poll_cnt_q + POLL_W'(1)) == POLL_W'(POLL_MAX);
    assign head_is_write = (head.op == OP_WRITE);

    // Next-state and next-output logic; every registered output is decided here.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        poll_cnt_d    = poll_cnt_q;
        bus_valid_d   = bus_valid_q;
        bus_write_d   = bus_write_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wstrb_d   = bus_wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    op_d       = op_e'(head.op);
                    addr_d     = head.addr;
                    wdata_d    = head.wdata;
                    mask_d     = head.mask;
                    poll_cnt_d = '0;
                    if (head.op == OP_RSVD) begin
                        state_d       = S_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d     = S_ISSUE;
                        bus_valid_d = 1'b1;
                        bus_write_d = head_is_write;
                        bus_addr_d  = head.addr;
                        bus_wdata_d = head_is_write ? head.wdata : '0;
                        bus_wstrb_d = head_is_write ? '1 : '0;
                    end
                end
            end

            S_ISSUE: begin
                if (reg_bus_ready_i) begin
                    bus_valid_d   = 1'b0;
                    rsp_error_d   = reg_bus_error_i;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = reg_bus_rdata_i;
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    if (op_q == OP_WRITE) begin
                        rsp_rdata_d = '0;
                    end else if (op_q == OP_POLL && !reg_bus_error_i && !poll_match) begin
                        if (poll_last) begin
                            rsp_timeout_d = 1'b1;
                        end else begin
                            // Another attempt follows after one idle bus cycle.
                            state_d     = S_GAP;
                            rsp_valid_d = 1'b0;
                            rsp_rdata_d = rsp_rdata_q;
                            rsp_error_d = rsp_error_q;
                            if (poll_cnt_q != POLL_W'(POLL_MAX)) begin
                                poll_cnt_d = poll_cnt_q + POLL_W'(1);
                            end
                        end
                    end
                end
            end

            S_GAP: begin
                state_d     = S_ISSUE;
                bus_valid_d = 1'b1;
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                bus_valid_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    // State, working and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            op_q          <= OP_WRITE;
            addr_q        <= '0;
            wdata_q       <= '0;
            mask_q        <= '0;
            poll_cnt_q    <= '0;
            bus_valid_q   <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_wstrb_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mask_q        <= mask_d;
            poll_cnt_q    <= poll_cnt_d;
            bus_valid_q   <= bus_valid_d;
            bus_write_q   <= bus_write_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wstrb_q   <= bus_wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready_o     = ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_error_o     = rsp_error_q;
    assign rsp_timeout_o   = rsp_timeout_q;
    assign busy_o          = busy_q;
    assign reg_bus_addr_o  = bus_addr_q;
    assign reg_bus_write_o = bus_write_q;
    assign reg_bus_wdata_o = bus_wdata_q;
    assign reg_bus_wstrb_o = bus_wstrb_q;
    assign reg_bus_valid_o = bus_valid_q;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator with a small scripted REG_BUS slave.
module tb_reg_bus_initiator;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          busy;
    logic [AW-1:0] bus_addr;
    logic          bus_write;
    logic [DW-1:0] bus_wdata;
    logic [3:0]    bus_wstrb;
    logic          bus_valid;
    logic          bus_ready = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_error = 1'b0;

    reg_bus_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .POLL_MAX   (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_op_i        (cmd_op),
        .cmd_addr_i      (cmd_addr),
        .cmd_wdata_i     (cmd_wdata),
        .cmd_mask_i      (cmd_mask),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_error_o     (rsp_error),
        .rsp_timeout_o   (rsp_timeout),
        .busy_o          (busy),
        .reg_bus_addr_o  (bus_addr),
        .reg_bus_write_o (bus_write),
        .reg_bus_wdata_o (bus_wdata),
        .reg_bus_wstrb_o (bus_wstrb),
        .reg_bus_valid_o (bus_valid),
        .reg_bus_ready_i (bus_ready),
        .reg_bus_rdata_i (bus_rdata),
        .reg_bus_error_i (bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scripted slave state.
    int          slv_wait = 0;
    int          slv_err_at = 0;
    int          acc = 0;
    int          wait_cnt = 0;
    int          vcyc = 0;
    int          stab_err = 0;
    int          overlap = 0;
    bit          in_xfer = 0;
    logic [31:0] slv_data[$];
    int          comp_t[$];
    logic [31:0] h_addr = '0;
    logic [31:0] h_wdata = '0;
    logic        h_write = 1'b0;
    logic [3:0]  h_wstrb = '0;

    // Slave: answers after slv_wait stall cycles, checks request stability.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rsp_valid && bus_valid) overlap++;
            bus_ready = 1'b0;
            bus_error = 1'b0;
            bus_rdata = '0;
            if (bus_valid) begin
                vcyc++;
                if (!in_xfer) begin
                    in_xfer = 1;
                    h_addr  = bus_addr;
                    h_wdata = bus_wdata;
                    h_write = bus_write;
                    h_wstrb = bus_wstrb;
                end else if (bus_addr != h_addr || bus_wdata != h_wdata ||
                             bus_write != h_write || bus_wstrb != h_wstrb) begin
                    stab_err++;
                end
                if (wait_cnt >= slv_wait) begin
                    bus_ready = 1'b1;
                    bus_rdata = (acc < slv_data.size()) ? slv_data[acc] : 32'h0;
                    bus_error = (acc + 1 == slv_err_at);
                    comp_t.push_back(cyc);
                    acc++;
                    wait_cnt = 0;
                    in_xfer  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slv_reset(input int w, input int e);
        slv_wait   = w;
        slv_err_at = e;
        acc        = 0;
        wait_cnt   = 0;
        vcyc       = 0;
        stab_err   = 0;
        in_xfer    = 0;
        comp_t.delete();
        slv_data.delete();
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] m);
        int b;
        b = 0;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_mask  = m;
        cmd_valid = 1'b1;
        while (!cmd_ready && b < 200) begin
            tick();
            b++;
        end
        if (b >= 200) check("push_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int b;
        b = 0;
        while (!rsp_valid && b < 300) begin
            tick();
            b++;
        end
        check("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bus_valid", 64'(bus_valid), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write 0x40 <- 0x1, exact latency
        slv_reset(0, 0);
        push(2'b00, 32'h40, 32'h1, 32'h0);
        check("wr_n1_valid", 64'(bus_valid), 64'd0);
        check("wr_n1_busy", 64'(busy), 64'd1);
        tick();
        check("wr_n2_valid", 64'(bus_valid), 64'd1);
        check("wr_n2_write", 64'(bus_write), 64'd1);
        check("wr_n2_wstrb", 64'(bus_wstrb), 64'hF);
        check("wr_n2_addr", 64'(bus_addr), 64'h40);
        check("wr_n2_wdata", 64'(bus_wdata), 64'h1);
        check("wr_n2_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("wr_n3_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_n3_bus_valid", 64'(bus_valid), 64'd0);
        check("wr_rsp_error", 64'(rsp_error), 64'd0);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("wr_rsp_timeout", 64'(rsp_timeout), 64'd0);
        take_rsp();
        check("wr_busy_after", 64'(busy), 64'd0);
        check("wr_rsp_valid_after", 64'(rsp_valid), 64'd0);

        // Read 0x0C with three stall cycles
        slv_reset(3, 0);
        slv_data.push_back(32'h4);
        push(2'b01, 32'h0C, 32'h0, 32'h0);
        wait_rsp();
        check("rd_valid_cycles", 64'(vcyc), 64'd4);
        check("rd_stable", 64'(stab_err), 64'd0);
        check("rd_addr", 64'(h_addr), 64'hC);
        check("rd_write", 64'(h_write), 64'd0);
        check("rd_wstrb", 64'(h_wstrb), 64'd0);
        check("rd_rdata", 64'(rsp_rdata), 64'h4);
        check("rd_error", 64'(rsp_error), 64'd0);
        take_rsp();

        // Poll 0x0C mask 0xF match 0x4, slave returns 1,2,3,4
        slv_reset(0, 0);
        for (int i = 1; i <= 4; i++) slv_data.push_back(32'(i));
        push(2'b10, 32'h0C, 32'h4, 32'hF);
        wait_rsp();
        check("poll_reads", 64'(acc), 64'd4);
        check("poll_valid_cycles", 64'(vcyc), 64'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < comp_t.size()) check("poll_spacing", 64'(comp_t[i] - comp_t[i-1]), 64'd2);
        end
        check("poll_wdata_bus", 64'(h_wdata), 64'd0);
        check("poll_rdata", 64'(rsp_rdata), 64'h4);
        check("poll_timeout", 64'(rsp_timeout), 64'd0);
        check("poll_error", 64'(rsp_error), 64'd0);
        take_rsp();

        // Poll that never matches: POLL_MAX=8 attempts then timeout
        slv_reset(0, 0);
        for (int i = 1; i <= 10; i++) slv_data.push_back(32'(i));
        push(2'b10, 32'h10, 32'hAA, 32'hFF);
        wait_rsp();
        check("pto_reads", 64'(acc), 64'd8);
        check("pto_timeout", 64'(rsp_timeout), 64'd1);
        check("pto_rdata", 64'(rsp_rdata), 64'h8);
        check("pto_error", 64'(rsp_error), 64'd0);
        take_rsp();

        // Poll hit by a bus error on attempt 3
        slv_reset(0, 3);
        for (int i = 1; i <= 10; i++) slv_data.push_back(32'(i));
        push(2'b10, 32'h10, 32'hAA, 32'hFF);
        wait_rsp();
        check("perr_reads", 64'(acc), 64'd3);
        check("perr_error", 64'(rsp_error), 64'd1);
        check("perr_timeout", 64'(rsp_timeout), 64'd0);
        take_rsp();

        // Five back-to-back reads with responses stalled, then a reserved op
        slv_reset(0, 0);
        for (int i = 0; i < 5; i++) slv_data.push_back(32'h11 + 32'(i));
        for (int i = 0; i < 5; i++) push(2'b01, 32'h100 + 32'(4 * i), 32'h0, 32'h0);
        check("fill_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        tick();
        check("fill_cmd_ready_held", 64'(cmd_ready), 64'd0);
        check("fill_rsp_valid", 64'(rsp_valid), 64'd1);
        check("fill_busy", 64'(busy), 64'd1);
        check("fill_rsp0", 64'(rsp_rdata), 64'h11);
        take_rsp();
        push(2'b11, 32'h200, 32'h0, 32'h0);
        for (int i = 1; i < 5; i++) begin
            wait_rsp();
            check("drain_rdata", 64'(rsp_rdata), 64'h11 + 64'(i));
            check("drain_error", 64'(rsp_error), 64'd0);
            take_rsp();
        end
        wait_rsp();
        check("rsvd_error", 64'(rsp_error), 64'd1);
        check("rsvd_rdata", 64'(rsp_rdata), 64'd0);
        check("rsvd_timeout", 64'(rsp_timeout), 64'd0);
        take_rsp();
        check("rsvd_no_bus", 64'(acc), 64'd5);
        check("drain_busy", 64'(busy), 64'd0);

        // Reset asserted while a read is stalled in ISSUE
        slv_reset(1000, 0);
        push(2'b01, 32'h20, 32'h0, 32'h0);
        for (int b = 0; b < 20 && !bus_valid; b++) tick();
        check("mid_valid", 64'(bus_valid), 64'd1);
        rst_n = 1'b0;
        #3;
        check("mid_rst_valid", 64'(bus_valid), 64'd0);
        check("mid_rst_addr", 64'(bus_addr), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        tick();
        slv_reset(0, 0);
        rst_n = 1'b1;
        tick();
        check("rerst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rerst_busy", 64'(busy), 64'd0);
        push(2'b00, 32'h44, 32'h55, 32'h0);
        wait_rsp();
        check("rerst_error", 64'(rsp_error), 64'd0);
        check("rerst_addr", 64'(h_addr), 64'h44);
        check("rerst_wdata", 64'(h_wdata), 64'h55);
        check("rerst_write", 64'(h_write), 64'd1);
        check("rerst_accesses", 64'(acc), 64'd1);
        take_rsp();

        check("rsp_bus_overlap", 64'(overlap), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
